// File: rtl/button_input_ctrl.sv
// Push-button front end: 2-FF sync, debounce, press/release/long-press pulses per button.
// Optional auto-repeat in LONG state is built when BTN_AUTOREPEAT_EN is defined.
module button_input_ctrl #(
    parameter int CLK_HZ      = 27000000,
    parameter int NUM_BTNS    = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NUM_BTNS-1:0] BTN_IN,
    output logic [NUM_BTNS-1:0] BTN_STATE,
    output logic [NUM_BTNS-1:0] PRESS_PULSE,
    output logic [NUM_BTNS-1:0] RELEASE_PULSE,
    output logic [NUM_BTNS-1:0] LONG_PULSE,
    output logic [NUM_BTNS-1:0] REPEAT_PULSE
);

    localparam int CYC_PER_MS = CLK_HZ / 1000;
    localparam int DB_RAW     = CYC_PER_MS * DEBOUNCE_MS;
    localparam int LONG_RAW   = CYC_PER_MS * LONG_MS;
    localparam int REP_RAW    = CYC_PER_MS * REPEAT_MS;
    localparam int DB_CYC     = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int LONG_CYC   = (LONG_RAW < 1) ? 1 : LONG_RAW;
    localparam int REP_CYC    = (REP_RAW < 1) ? 1 : REP_RAW;
    localparam int DB_W       = $clog2(DB_CYC + 1);
    localparam int HOLD_W     = $clog2(LONG_CYC + 1);
    localparam int REP_W      = $clog2(REP_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } btn_fsm_e;

    logic [NUM_BTNS-1:0] pressed_raw;
    logic [NUM_BTNS-1:0] sync1;
    logic [NUM_BTNS-1:0] sync2;

    assign pressed_raw = (ACTIVE_LOW != 0) ? ~BTN_IN : BTN_IN;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pressed_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        logic [DB_W-1:0]   db_cnt;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              long_d;
        logic [HOLD_W-1:0] hold_cnt;
        logic [HOLD_W-1:0] hold_d;
        btn_fsm_e          state_q;
        btn_fsm_e          state_d;
        logic              accept;
        logic              accept_press;
        logic              accept_release;

        // A level change is accepted on the edge where the mismatch has lasted DB_CYC cycles.
        assign accept         = (sync2[i] != level_q) && (db_cnt == DB_LAST);
        assign accept_press   = accept && sync2[i];
        assign accept_release = accept && !sync2[i];

        always_ff @(posedge CLK) begin
            if (!nRST) begin
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= accept_press;
                release_q <= accept_release;
                if (sync2[i] == level_q) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    level_q <= sync2[i];
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (!nRST) begin
                state_q  <= IDLE;
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                hold_cnt <= hold_d;
                long_q   <= long_d;
            end
        end

        // Release is checked before the long-press threshold so it wins a same-cycle tie.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_cnt;
            long_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_press) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
                HOLD: begin
                    if (accept_release) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else if (hold_cnt == LONG_LAST) begin
                        state_d = LONG;
                        hold_d  = '0;
                        long_d  = 1'b1;
                    end else begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (accept_release) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [REP_W-1:0] rep_cnt;
        logic             rep_q;

        always_ff @(posedge CLK) begin
            if (!nRST || (state_q != LONG) || accept_release) begin
                rep_cnt <= '0;
                rep_q   <= 1'b0;
            end else if (rep_cnt == REP_LAST) begin
                rep_cnt <= '0;
                rep_q   <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
                rep_q   <= 1'b0;
            end
        end

        assign REPEAT_PULSE[i] = rep_q;
`else
        assign REPEAT_PULSE[i] = 1'b0;
`endif

        assign BTN_STATE[i]     = level_q;
        assign PRESS_PULSE[i]   = press_q;
        assign RELEASE_PULSE[i] = release_q;
        assign LONG_PULSE[i]    = long_q;
    end

endmodule

// File: tb/tb_button_input_ctrl.sv
// Bench for button_input_ctrl: directed scenarios plus random pin activity, every cycle
// compared against an event-timestamp reference model through an expected-value queue.
module tb_button_input_ctrl;

    localparam int NB       = 2;
    localparam int DB_CYC   = 4;
    localparam int LONG_CYC = 20;
    localparam int REP_CYC  = 5;
    localparam int VW       = 5 * NB;

    logic          CLK;
    logic          nRST;
    logic [NB-1:0] BTN_IN;
    logic [NB-1:0] BTN_STATE;
    logic [NB-1:0] PRESS_PULSE;
    logic [NB-1:0] RELEASE_PULSE;
    logic [NB-1:0] LONG_PULSE;
    logic [NB-1:0] REPEAT_PULSE;

    button_input_ctrl #(
        .CLK_HZ     (1000),
        .NUM_BTNS   (NB),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20),
        .REPEAT_MS  (5),
        .ACTIVE_LOW (1)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .BTN_IN       (BTN_IN),
        .BTN_STATE    (BTN_STATE),
        .PRESS_PULSE  (PRESS_PULSE),
        .RELEASE_PULSE(RELEASE_PULSE),
        .LONG_PULSE   (LONG_PULSE),
        .REPEAT_PULSE (REPEAT_PULSE)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // scoreboard state
    logic [VW-1:0] exp_q[$];
    int            checks;
    int            errors;
    int            edge_n;

    // reference model: pressed level seen through a 2-stage delay, accepted after
    // DB_CYC consecutive edges of disagreement; pulses derived from press timestamps
    bit            m_s1[NB];
    bit            m_s2[NB];
    bit            m_acc[NB];
    int            m_run[NB];
    int            m_press_edge[NB];

    task automatic model_edge(input logic [NB-1:0] pr, input logic rst_n);
        logic [NB-1:0] st, pp, rp, lp, qp;
        int age;
        st = '0; pp = '0; rp = '0; lp = '0; qp = '0;
        for (int b = 0; b < NB; b++) begin
            if (!rst_n) begin
                m_s1[b] = 1'b0;
                m_s2[b] = 1'b0;
                m_acc[b] = 1'b0;
                m_run[b] = 0;
                m_press_edge[b] = -1;
            end else begin
                if (m_s2[b] != m_acc[b]) m_run[b]++;
                else m_run[b] = 0;
                if (m_run[b] == DB_CYC) begin
                    m_acc[b] = m_s2[b];
                    m_run[b] = 0;
                    if (m_acc[b]) begin
                        pp[b] = 1'b1;
                        m_press_edge[b] = edge_n;
                    end else begin
                        rp[b] = 1'b1;
                        m_press_edge[b] = -1;
                    end
                end
                if (m_press_edge[b] >= 0) begin
                    age = edge_n - m_press_edge[b];
                    if (age == LONG_CYC) lp[b] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    if (age > LONG_CYC && ((age - LONG_CYC) % REP_CYC) == 0) qp[b] = 1'b1;
`endif
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = pr[b];
            end
            st[b] = m_acc[b];
        end
        exp_q.push_back({qp, lp, rp, pp, st});
        edge_n++;
    endtask

    // driver: one clock per call; pressed is the logical level, pins are active-low
    task automatic step(input logic [NB-1:0] pressed, input logic rst_n);
        @(negedge CLK);
        BTN_IN = ~pressed;
        nRST   = rst_n;
        @(posedge CLK);
        model_edge(pressed, rst_n);
    endtask

    task automatic hold(input logic [NB-1:0] pressed, input int n);
        for (int i = 0; i < n; i++) step(pressed, 1'b1);
    endtask

    // monitor: outputs are valid every cycle, one expected vector per edge
    always @(negedge CLK) begin
        logic [VW-1:0] exp_v;
        logic [VW-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {REPEAT_PULSE, LONG_PULSE, RELEASE_PULSE, PRESS_PULSE, BTN_STATE};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t actual rep/long/rel/press/state=%b required %b",
                         $time, act_v, exp_v);
            end
        end
    end

    logic [NB-1:0] lvl;
    int            dur[NB];

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        nRST   = 1'b0;
        BTN_IN = '1;

        for (int i = 0; i < 3; i++) step(2'b00, 1'b0);
        hold(2'b00, 5);

        // long press on button 0, held through repeats, then release
        hold(2'b01, 40);
        hold(2'b00, 10);

        // glitches on button 1: 3 cycles rejected, 4 cycles accepted
        hold(2'b10, 3);
        hold(2'b00, 10);
        hold(2'b10, 4);
        hold(2'b00, 12);

        // simultaneous press and release on both buttons
        hold(2'b11, 12);
        hold(2'b00, 12);

        // release landing right around the long-press threshold
        for (int n = 19; n <= 21; n++) begin
            hold(2'b01, n);
            hold(2'b00, 12);
        end

        // reset mid-hold with the button still down
        hold(2'b01, 12);
        step(2'b01, 1'b0);
        hold(2'b01, 10);
        hold(2'b00, 10);

        // random pin activity with occasional resets
        lvl = '0;
        for (int b = 0; b < NB; b++) dur[b] = $urandom_range(1, 20);
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < NB; b++) begin
                if (dur[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    dur[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                          : $urandom_range(5, 45);
                end
                dur[b]--;
            end
            step(lvl, ($urandom_range(0, 299) != 0));
        end
        hold(2'b00, 10);

        repeat (3) @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
